// File: rtl/ps2_key_tracker.sv
`timescale 1ns/1ps
// ps2_key_tracker
// Decodes the PS/2 received-byte stream (make, F0 break, E0 extended
// prefixes) against a runtime key map, keeps a held bit per mapped key and
// emits one-cycle action pulses, optionally with delayed auto-repeat.
//
// Optional feature: define KEY_AUTOREPEAT_EN to build the per-key repeat
// counters. Without it, tick_en/DAS_DELAY/ARR_PERIOD are ignored and a key
// pulses only on a fresh make.
//
// Ports:
//   CLOCK_50   in  system clock (rising edge)
//   reset      in  asynchronous active-high reset
//   rx_data    in  [7:0] received byte
//   rx_valid   in  one-cycle strobe qualifying rx_data
//   key_map    in  [9*NUM_KEYS-1:0] entry k = {ext, scan code} at [9k+8:9k]
//   tick_en    in  repeat time-base strobe
//   clear_all  in  synchronous drop of all held keys / repeats
//   key_held   out [NUM_KEYS-1:0] key currently pressed
//   key_pulse  out [NUM_KEYS-1:0] one-cycle action strobe per key
//   any_held   out OR of key_held
//   last_idx   out [3:0] index of last key that produced a make pulse
//
// Handshake: rx_valid is a pure strobe with no ready/backpressure; every
// cycle it is high the byte in rx_data is consumed by the parser.
module ps2_key_tracker #(
  parameter int NUM_KEYS   = 8,
  parameter int DAS_DELAY  = 12,
  parameter int ARR_PERIOD = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [9*NUM_KEYS-1:0] key_map,
  input  logic                  tick_en,
  input  logic                  clear_all,
  output logic [NUM_KEYS-1:0]   key_held,
  output logic [NUM_KEYS-1:0]   key_pulse,
  output logic                  any_held,
  output logic [3:0]            last_idx
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic is_e0, is_f0, is_prefix;
  logic code_ev, code_ext, code_brk;

  assign is_e0     = (rx_data == 8'hE0);
  assign is_f0     = (rx_data == 8'hF0);
  assign is_prefix = is_e0 | is_f0;

  // Parser state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Parser next state
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE:    state_d = is_e0 ? ST_EXT : (is_f0 ? ST_BRK : ST_IDLE);
        ST_EXT:     state_d = is_f0 ? ST_EXT_BRK : (is_e0 ? ST_EXT : ST_IDLE);
        ST_BRK:     state_d = is_e0 ? ST_EXT_BRK : (is_f0 ? ST_BRK : ST_IDLE);
        ST_EXT_BRK: state_d = is_prefix ? ST_EXT_BRK : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Parser outputs: a non-prefix byte is a make/break code whose flavour
  // comes from the prefixes collected so far.
  always_comb begin
    code_ev  = rx_valid && !is_prefix;
    code_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    code_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  end

  // Key lookup: scan downwards so the lowest matching index wins.
  logic       match_hit;
  logic [3:0] match_idx;

  always_comb begin
    match_hit = 1'b0;
    match_idx = 4'd0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (key_map[9*k +: 9] == {code_ext, rx_data}) begin
        match_hit = 1'b1;
        match_idx = 4'(k);
      end
    end
  end

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [3:0]          last_idx_q, last_idx_d;
  logic [NUM_KEYS-1:0] fresh_make;
  logic [NUM_KEYS-1:0] brk_key;
  logic [NUM_KEYS-1:0] rep_fire;

  // Per-key events; a make on an already-held key (typematic) is not fresh.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      fresh_make[k] = code_ev && !code_brk && match_hit &&
                      (match_idx == 4'(k)) && !held_q[k];
      brk_key[k]    = code_ev && code_brk && match_hit && (match_idx == 4'(k));
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [CNT_W-1:0] cnt_q [NUM_KEYS];
  logic [CNT_W-1:0] cnt_d [NUM_KEYS];

  // Repeat counters: count down on tick while held, fire when leaving 1.
  // Any key that will not be held next cycle parks its counter at 0.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_fire[k] = 1'b0;
      cnt_d[k]    = cnt_q[k];
      if (held_q[k] && tick_en && (cnt_q[k] != '0)) begin
        if (cnt_q[k] == CNT_W'(1)) begin
          rep_fire[k] = 1'b1;
          cnt_d[k]    = CNT_W'(ARR_PERIOD);
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
      if (clear_all || brk_key[k] || !(held_q[k] || fresh_make[k])) begin
        cnt_d[k] = '0;
      end else if (fresh_make[k]) begin
        cnt_d[k] = CNT_W'(DAS_DELAY);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end
`else
  logic unused_tick_en;
  assign unused_tick_en = tick_en;
  assign rep_fire       = '0;
`endif

  // Held/pulse/last: clear_all beats everything, a break beats a repeat
  // expiry in the same cycle, and a fresh make and a repeat can only merge
  // into one pulse.
  always_comb begin
    held_d     = held_q;
    pulse_d    = '0;
    last_idx_d = last_idx_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (clear_all || brk_key[k]) begin
        held_d[k] = 1'b0;
      end else begin
        if (fresh_make[k]) begin
          held_d[k]  = 1'b1;
          last_idx_d = 4'(k);
        end
        pulse_d[k] = fresh_make[k] || rep_fire[k];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      pulse_q    <= '0;
      last_idx_q <= 4'd0;
    end else begin
      held_q     <= held_d;
      pulse_q    <= pulse_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign key_held  = held_q;
  assign key_pulse = pulse_q;
  assign any_held  = |held_q;
  assign last_idx  = last_idx_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps
// Bench for ps2_key_tracker: directed key sequences with literal
// expectations, then randomized byte/tick/clear traffic checked every cycle
// against a prefix-flag / tick-count reference model.
module tb_ps2_key_tracker;

  localparam int NK  = 8;
  localparam int DAS = 12;
  localparam int ARR = 4;
  localparam int W   = 20;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [9*NK-1:0] key_map;
  logic            tick_en;
  logic            clear_all;
  logic [NK-1:0]   key_held;
  logic [NK-1:0]   key_pulse;
  logic            any_held;
  logic [3:0]      last_idx;

  ps2_key_tracker #(
    .NUM_KEYS(NK), .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .CNT_W(8)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .key_map  (key_map),
    .tick_en  (tick_en),
    .clear_all(clear_all),
    .key_held (key_held),
    .key_pulse(key_pulse),
    .any_held (any_held),
    .last_idx (last_idx)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // k0=A, k1=E0 left arrow, k6 = extended twin of A, k7 duplicates A
  logic [8:0] map_tbl [NK] = '{9'h01C, 9'h16B, 9'h01B, 9'h023,
                               9'h174, 9'h029, 9'h11C, 9'h01C};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags plus ticks seen since make.
  logic [W-1:0] exp_q[$];
  logic [NK-1:0] m_held, m_pulse, nh, np;
  logic [3:0]    m_last;
  int            m_ticks [NK];
  bit            m_ext, m_brk, ev, ev_ext, ev_brk, rep;
  int            hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held = '0; m_pulse = '0; m_last = 4'd0; m_ext = 0; m_brk = 0;
      for (int k = 0; k < NK; k++) m_ticks[k] = 0;
      exp_q.delete();
    end else begin
      ev = 0; ev_ext = 0; ev_brk = 0;
      if (rx_valid) begin
        if (rx_data == 8'hE0) m_ext = 1;
        else if (rx_data == 8'hF0) m_brk = 1;
        else begin
          ev = 1; ev_ext = m_ext; ev_brk = m_brk; m_ext = 0; m_brk = 0;
        end
      end
      hit = -1;
      if (ev) for (int k = 0; k < NK; k++)
        if (hit < 0 && map_tbl[k] == {ev_ext, rx_data}) hit = k;
      nh = m_held; np = '0;
      for (int k = 0; k < NK; k++) begin
        rep = 0;
        if (m_held[k] && tick_en) begin
          m_ticks[k]++;
          rep = AUTOREP && (m_ticks[k] == DAS ||
                (m_ticks[k] > DAS && (m_ticks[k] - DAS) % ARR == 0));
        end
        if (clear_all) nh[k] = 0;
        else if (hit == k && ev_brk) nh[k] = 0;
        else if (hit == k && !m_held[k]) begin
          nh[k] = 1; np[k] = 1; m_ticks[k] = 0; m_last = 4'(k);
        end else np[k] = rep;
      end
      m_held = nh; m_pulse = np;
      exp_q.push_back({m_last, m_held, m_pulse});
    end
  end

  // Scoreboard compare, every cycle out of reset
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      chk("sb_held",  32'(key_held),  32'(e[15:8]));
      chk("sb_pulse", 32'(key_pulse), 32'(e[7:0]));
      chk("sb_any",   32'(any_held),  32'(|e[15:8]));
      chk("sb_last",  32'(last_idx),  32'(e[19:16]));
    end
  end

  // Driver tasks: called just after a rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  logic [7:0] byte_tbl [12] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1C, 8'h6B,
                                8'h1B, 8'h23, 8'h74, 8'h29, 8'h1C, 8'h6B};
  logic [NK-1:0] exp_p;

  initial begin
    rx_valid = 0; rx_data = 0; tick_en = 0; clear_all = 0; rst = 0;
    for (int k = 0; k < NK; k++) key_map[9*k +: 9] = map_tbl[k];
    #5 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_pulse", 32'(key_pulse), 0);
    chk("rst_any", 32'(any_held), 0);
    chk("rst_last", 32'(last_idx), 0);

    // Make A: lowest index wins over the duplicate at k7
    step(); send_byte(8'h1C);
    @(negedge clk);
    chk("make_a_pulse", 32'(key_pulse), 32'h01);
    chk("make_a_held", 32'(key_held), 32'h01);
    chk("make_a_any", 32'(any_held), 1);
    step(); @(negedge clk);
    chk("make_a_one_cycle", 32'(key_pulse), 0);
    step(); send_byte(8'hF0);
    @(negedge clk);
    chk("f0_still_held", 32'(key_held), 32'h01);
    step(); send_byte(8'h1C);
    @(negedge clk);
    chk("brk_a_held", 32'(key_held), 0);
    chk("brk_a_no_pulse", 32'(key_pulse), 0);

    // Extended left arrow, then bare 6B (unmapped)
    step(); send_byte(8'hE0); send_byte(8'h6B);
    @(negedge clk);
    chk("left_pulse", 32'(key_pulse), 32'h02);
    chk("left_last", 32'(last_idx), 1);
    step(); send_byte(8'h6B);
    @(negedge clk);
    chk("bare_6b_pulse", 32'(key_pulse), 0);
    chk("bare_6b_held", 32'(key_held), 32'h02);
    step(); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    @(negedge clk);
    chk("left_release", 32'(key_held), 0);
    step(); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    @(negedge clk);
    chk("brk_not_held", 32'(key_held), 0);
    chk("brk_not_held_p", 32'(key_pulse), 0);

    // Hold A with ticks on; typematic resend at +5; break bytes at +30/+31
    tick_en = 1;
    step(); send_byte(8'h1C);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (AUTOREP)
        exp_p = (i == 1 || i == 13 || i == 17 || i == 21 || i == 25 || i == 29) ? 8'h01 : 8'h00;
      else
        exp_p = (i == 1) ? 8'h01 : 8'h00;
      chk("repeat_pulse", 32'(key_pulse), 32'(exp_p));
      chk("repeat_held", 32'(key_held), (i <= 31) ? 32'h01 : 32'h00);
      rx_valid = (i == 5 || i == 30 || i == 31);
      rx_data  = (i == 30) ? 8'hF0 : 8'h1C;
    end
    rx_valid = 0;
    tick_en = 0;

    // Reset after F0 discards the break prefix
    step(); send_byte(8'hF0);
    rst = 1;
    step(); step();
    rst = 0;
    send_byte(8'h1C);
    @(negedge clk);
    chk("rst_prefix_pulse", 32'(key_pulse), 32'h01);
    chk("rst_prefix_held", 32'(key_held), 32'h01);

    // clear_all with A and left held, then clear_all colliding with a make
    step(); send_byte(8'hE0); send_byte(8'h6B);
    @(negedge clk);
    chk("both_held", 32'(key_held), 32'h03);
    step(); clear_all = 1; step(); clear_all = 0;
    @(negedge clk);
    chk("clear_held", 32'(key_held), 0);
    chk("clear_pulse", 32'(key_pulse), 0);
    step(); rx_data = 8'h1C; rx_valid = 1; clear_all = 1;
    step(); rx_valid = 0; clear_all = 0;
    @(negedge clk);
    chk("clear_make_held", 32'(key_held), 0);
    chk("clear_make_pulse", 32'(key_pulse), 0);

    // Random traffic, checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      step();
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_data   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : byte_tbl[$urandom_range(0, 11)];
      tick_en   = ($urandom_range(0, 1) == 1);
      clear_all = ($urandom_range(0, 99) == 0);
    end
    step();
    rx_valid = 0; tick_en = 0; clear_all = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 scan-code tracker sitting between `PS2_Controller` and the gameplay/menu FSMs. It consumes the raw received-byte stream and decodes make, break (`F0`) and extended (`E0`) sequences against a runtime key map. It keeps a held bit per mapped key and emits one-cycle action pulses with delayed auto-repeat. It replaces single-byte "last code equals X" level decoding, so keys can be held, combined and released cleanly.

## Interface
Parameters:
- `NUM_KEYS`, 8: number of tracked keys (1..16).
- `DAS_DELAY`, 12: ticks from make to first auto-repeat pulse (>=1).
- `ARR_PERIOD`, 4: ticks between subsequent repeat pulses (>=1).
- `CNT_W`, 8: repeat counter width; must hold max(`DAS_DELAY`, `ARR_PERIOD`).

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte from `PS2_Controller`.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `key_map`  in  9*NUM_KEYS  entry k = bits [9k+8:9k]; bit 8 = extended (`E0`) flag, bits 7:0 = scan code. Treated as static.
- `tick_en`  in  1  repeat time-base enable (one-cycle strobe from a divider counter).
- `clear_all`  in  1  synchronous: drop all held keys, cancel repeat.
- `key_held`  out  NUM_KEYS  level, key k currently pressed.
- `key_pulse`  out  NUM_KEYS  one-cycle action strobe per key.
- `any_held`  out  1  OR of `key_held`.
- `last_idx`  out  4  index of last key that produced a make pulse.

## Operation
- Parser FSM, advanced only on `rx_valid`:
  - IDLE: `E0`→EXT, `F0`→BRK, other byte = make (ext=0).
  - EXT: `F0`→EXT_BRK, `E0`→EXT, other = make (ext=1).
  - BRK: `F0`→BRK, `E0`→EXT_BRK, other = break (ext=0).
  - EXT_BRK: `F0`/`E0`→EXT_BRK, other = break (ext=1).
  - After a make/break byte, always →IDLE.
- Lookup: the lowest index k whose map entry equals {ext, byte} matches. Unmapped codes are ignored, but the FSM still returns to IDLE.
- Make on key k with `key_held[k]`=0:
  - Set held.
  - Pulse k.
  - Load `cnt[k]`=`DAS_DELAY`.
  - Set `last_idx`=k.
- Make on a key already held (keyboard typematic) is ignored: no pulse, counter untouched.
- Break on key k: clear held, no pulse. Break on a key not held is ignored.
- Repeat: while `key_held[k]`, each cycle with `tick_en`=1 decrements `cnt[k]`. On a decrement from 1, pulse k and reload `ARR_PERIOD`.
- Simultaneous events:
  - Make and repeat expiry for the same key in one cycle yield exactly one pulse.
  - `clear_all` wins over any same-cycle make or repeat: no pulse, held cleared. Parser state is kept.
- Counters of non-held keys hold 0 and never pulse.

## Timing
- Reset values: `key_held`=0, `key_pulse`=0, `any_held`=0, `last_idx`=0, all counters 0, FSM=IDLE.
- Reset mid-sequence (e.g. after `E0` or `F0`) discards the prefix.
- Make/break byte with `rx_valid` at cycle n:
  - `key_held`, `key_pulse`, `last_idx` update at n+1 (registered).
  - `any_held` follows combinationally from `key_held`.
- `key_pulse` is exactly one cycle wide. Pulses of different keys may coincide.
- With `tick_en` constant 1 and make at n:
  - First pulse at n+1.
  - Repeats at n+1+DAS_DELAY, then every ARR_PERIOD cycles, until break.
- Break at n removes the held state at n+1. A repeat scheduled for n+1 is suppressed.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: repeat counters and repeat pulses present as above.
- `KEY_AUTOREPEAT_EN` undefined:
  - Counters are not built; `tick_en`, `DAS_DELAY`, `ARR_PERIOD` are ignored.
  - `key_pulse` fires only on a fresh make.
  - Held/break behaviour is unchanged.

## Test plan
- Map k0=`{0,1C}` (A), k1=`{1,6B}` (left arrow). Send `1C`, then `F0 1C`: `key_pulse[0]` 1 cycle after `1C`, `key_held[0]`=1 until 1 cycle after the final `1C`, then 0. No pulse on break.
- Send `E0 6B`: only `key_pulse[1]`, `last_idx`=1. Send `6B` alone: no pulse on any key, FSM back to IDLE.
- With `KEY_AUTOREPEAT_EN`, `tick_en`=1, DAS=12, ARR=4, hold A for 30 cycles: pulses at +1, +13, +17, +21, +25, +29. None after break.
- Hold A and press `1C` again (typematic) mid-DAS: no extra pulse, repeat schedule unchanged. Send `E0 F0 6B` while k1 not held: no change.
- Assert `reset` after `F0`, release, send `1C`: make pulse on k0, not treated as break. `clear_all` while A and left are held: both held bits 0 next cycle, no pulses.
- Without the macro, hold A for 40 cycles: exactly one pulse.
